eviction_write_queue: RTL and testbench
=======================================

EVICTION_WRITE_QUEUE -- requirements
Module: eviction_write_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of buffered evicted lines; power of two, >= 2.
REQ-002 Parameter ADDR_WIDTH, default 16, pmem byte-address width (lc3b_word).
REQ-003 Parameter DATA_WIDTH, default 256, line width in bits (lc3b_pmem_data).
REQ-004 Ports SHALL be:
  clk              in   1           single clock, rising edge
  rst              in   1           synchronous, active-high reset
  l2_pmem_read     in   1           L2 line read request, held until l2_pmem_resp
  l2_pmem_write    in   1           L2 eviction write request, held until l2_pmem_resp
  l2_pmem_address  in   ADDR_WIDTH  L2 request line address
  l2_pmem_wdata    in   DATA_WIDTH  evicted line data
  l2_pmem_rdata    out  DATA_WIDTH  read return data, valid with l2_pmem_resp
  l2_pmem_resp     out  1           one-cycle completion pulse to L2
  pmem_resp        in   1           physical memory completion
  pmem_rdata       in   DATA_WIDTH  physical memory read data
  pmem_read        out  1           physical memory read strobe
  pmem_write       out  1           physical memory write strobe
  pmem_address     out  ADDR_WIDTH  physical memory address
  pmem_wdata       out  DATA_WIDTH  physical memory write data
  ewb_empty        out  1           no entries held
  ewb_full         out  1           DEPTH entries held

Function
REQ-005 Storage: DEPTH entries {valid, line address, data}; circular FIFO, head/tail pointers wrap modulo DEPTH; count 0..DEPTH.
REQ-006 Address match: compare bits [ADDR_WIDTH-1:OFFSET] only, OFFSET = log2(DATA_WIDTH/8).
REQ-007 FSM states IDLE, MEM_READ, DRAIN, RESP; requests sampled only in IDLE.
REQ-008 IDLE, write, address matches a valid entry: overwrite that entry's data in place (coalesce), count unchanged, -> RESP.
REQ-009 IDLE, write, no match, not full: enqueue at tail, count+1, -> RESP.
REQ-010 IDLE, write, no match, full: -> DRAIN; after drain completes, return to IDLE and re-sample the held write.
REQ-011 IDLE, read, match: l2_pmem_rdata = matching entry data (forwarding), -> RESP; pmem untouched.
REQ-012 IDLE, read, no match: -> MEM_READ; pmem_read=1, pmem_address=l2_pmem_address until pmem_resp; capture pmem_rdata; -> RESP.
REQ-013 IDLE, no request, not empty: -> DRAIN.
REQ-014 DRAIN: pmem_write=1, pmem_address/pmem_wdata = head entry until pmem_resp; on pmem_resp pop head, count-1, -> IDLE.
REQ-015 A request arriving during DRAIN or MEM_READ waits; an in-flight pmem transaction is never aborted except by rst.
REQ-016 RESP: l2_pmem_resp=1 for exactly one cycle, inputs ignored, -> IDLE; latency on hit or accepted write = 2 cycles from request assertion to resp.
REQ-017 Read and write asserted together: read serviced; write stays pending.
REQ-018 Write data visible to reads starting the cycle after RESP for that write.
REQ-019 pmem_read and pmem_write SHALL never be asserted together.
REQ-020 ewb_empty = (count==0), ewb_full = (count==DEPTH), both registered-state derived.

Reset
REQ-021 rst at rising edge: state IDLE, pointers 0, count 0, all valid bits 0; entry data not cleared.
REQ-022 Following cycle: pmem_read=0, pmem_write=0, l2_pmem_resp=0, ewb_empty=1, ewb_full=0; rst mid-DRAIN/MEM_READ abandons the transaction and discards buffered lines.

Structure
REQ-023 lc3b_types SHALL hold the state enum (ewb_state_t) and EWB_DEPTH default constant.
REQ-024 Sub-module ewb_entry_array: storage, pointers, count, parallel address match with match index; FSM in the top.

Verification
REQ-025 Write 0x1000 then read 0x1000 -> read resp 2 cycles after request, rdata = written line, no pmem_read.
REQ-026 Four writes 0x1000..0x1060 with pmem_resp held off -> ewb_full=1; fifth write 0x1080 -> pmem_write with address 0x1000 first, write accepted only after pmem_resp.
REQ-027 Write 0x2000 data A, then 0x2000 data B -> count stays 1; subsequent drain writes B once.
REQ-028 Read miss 0x3000, pmem_resp after 5 cycles with data C -> l2_pmem_rdata=C with resp, no drain interleaved.
REQ-029 Idle with 3 entries -> three FIFO-ordered pmem_writes, ewb_empty=1 after third pmem_resp.
REQ-030 rst asserted mid-DRAIN -> pmem_write=0 next cycle, ewb_empty=1, later read to drained-pending address misses to pmem.

Source files
------------

// File: rtl/lc3b_types.sv
// Shared types and constants for the eviction write buffer between L2 and
// physical memory.
package lc3b_types;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_READ = 2'd1,
        DRAIN    = 2'd2,
        RESP     = 2'd3
    } ewb_state_t;

    localparam int EWB_DEPTH      = 4;
    localparam int EWB_ADDR_WIDTH = 16;
    localparam int EWB_DATA_WIDTH = 256;

    // Byte-offset bits inside one line; these are ignored when matching.
    function automatic int ewb_line_offset(input int data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/ewb_entry_array.sv
// Circular store of evicted lines: valid/tag/data per entry, head/tail
// pointers, occupancy count and a parallel tag match against one lookup tag.
module ewb_entry_array
    import lc3b_types::*;
#(
    parameter int DEPTH      = EWB_DEPTH,
    parameter int TAG_WIDTH  = 11,
    parameter int DATA_WIDTH = EWB_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [TAG_WIDTH-1:0]  i_lookup_tag,
    input  logic                  i_enq,
    input  logic                  i_coalesce,
    input  logic                  i_pop,
    input  logic [TAG_WIDTH-1:0]  i_wr_tag,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    output logic                  o_match,
    output logic [DATA_WIDTH-1:0] o_match_data,
    output logic [TAG_WIDTH-1:0]  o_head_tag,
    output logic [DATA_WIDTH-1:0] o_head_data,
    output logic                  o_empty,
    output logic                  o_full
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [TAG_WIDTH-1:0]  r_tag  [DEPTH];
    logic [DATA_WIDTH-1:0] r_data [DEPTH];
    logic [DEPTH-1:0]      r_valid;
    logic [IDX_W-1:0]      r_head;
    logic [IDX_W-1:0]      r_tail;
    logic [CNT_W-1:0]      r_count;
    logic [DEPTH-1:0]      w_hit;
    logic [IDX_W-1:0]      w_match_idx;
    logic                  w_do_enq;
    logic                  w_do_pop;

    assign o_empty  = (r_count == '0);
    assign o_full   = (r_count == CNT_W'(DEPTH));
    assign w_do_enq = i_enq && !o_full;
    assign w_do_pop = i_pop && !o_empty;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
        assign w_hit[gi] = r_valid[gi] && (r_tag[gi] == i_lookup_tag);
    end

    // Coalescing keeps tags unique, so at most one hit; lowest index wins anyway.
    always_comb begin
        w_match_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (w_hit[i]) begin
                w_match_idx = IDX_W'(i);
            end
        end
    end

    assign o_match      = |w_hit;
    assign o_match_data = r_data[w_match_idx];
    assign o_head_tag   = r_tag[r_head];
    assign o_head_data  = r_data[r_head];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_enq) begin
                r_valid[r_tail] <= 1'b1;
                r_tail          <= r_tail + IDX_W'(1);
            end
            if (w_do_pop) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + IDX_W'(1);
            end
            if (w_do_enq && !w_do_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_do_enq && w_do_pop) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    // Line payloads survive reset; only the valid bits are cleared.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (w_do_enq && (r_tail == IDX_W'(i))) begin
                r_tag[i]  <= i_wr_tag;
                r_data[i] <= i_wr_data;
            end else if (i_coalesce && o_match && (w_match_idx == IDX_W'(i))) begin
                r_data[i] <= i_wr_data;
            end
        end
    end

endmodule

// File: rtl/eviction_write_queue.sv
// Eviction write buffer: absorbs L2 victim writes, forwards hits to L2 reads,
// and drains buffered lines to physical memory while L2 is quiet.
module eviction_write_queue
    import lc3b_types::*;
#(
    parameter int DEPTH      = EWB_DEPTH,
    parameter int ADDR_WIDTH = EWB_ADDR_WIDTH,
    parameter int DATA_WIDTH = EWB_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  l2_pmem_read,
    input  logic                  l2_pmem_write,
    input  logic [ADDR_WIDTH-1:0] l2_pmem_address,
    input  logic [DATA_WIDTH-1:0] l2_pmem_wdata,
    output logic [DATA_WIDTH-1:0] l2_pmem_rdata,
    output logic                  l2_pmem_resp,
    input  logic                  pmem_resp,
    input  logic [DATA_WIDTH-1:0] pmem_rdata,
    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic [DATA_WIDTH-1:0] pmem_wdata,
    output logic                  ewb_empty,
    output logic                  ewb_full
);

    localparam int OFFSET = ewb_line_offset(DATA_WIDTH);
    localparam int TAG_W  = ADDR_WIDTH - OFFSET;

    ewb_state_t            r_state;
    ewb_state_t            w_state_next;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [TAG_W-1:0]      w_req_tag;
    logic [TAG_W-1:0]      w_head_tag;
    logic [DATA_WIDTH-1:0] w_head_data;
    logic [DATA_WIDTH-1:0] w_match_data;
    logic                  w_match;
    logic                  w_enq;
    logic                  w_coalesce;
    logic                  w_pop;
    logic                  w_capture_hit;
    logic                  w_capture_mem;

    assign w_req_tag     = l2_pmem_address[ADDR_WIDTH-1:OFFSET];
    assign l2_pmem_rdata = r_rdata;

    ewb_entry_array #(
        .DEPTH      (DEPTH),
        .TAG_WIDTH  (TAG_W),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_entries (
        .clk          (clk),
        .rst          (rst),
        .i_lookup_tag (w_req_tag),
        .i_enq        (w_enq),
        .i_coalesce   (w_coalesce),
        .i_pop        (w_pop),
        .i_wr_tag     (w_req_tag),
        .i_wr_data    (l2_pmem_wdata),
        .o_match      (w_match),
        .o_match_data (w_match_data),
        .o_head_tag   (w_head_tag),
        .o_head_data  (w_head_data),
        .o_empty      (ewb_empty),
        .o_full       (ewb_full)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (w_capture_hit) begin
            r_rdata <= w_match_data;
        end else if (w_capture_mem) begin
            r_rdata <= pmem_rdata;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        pmem_read     = 1'b0;
        pmem_write    = 1'b0;
        pmem_address  = {w_head_tag, {OFFSET{1'b0}}};
        pmem_wdata    = w_head_data;
        l2_pmem_resp  = 1'b0;
        w_enq         = 1'b0;
        w_coalesce    = 1'b0;
        w_pop         = 1'b0;
        w_capture_hit = 1'b0;
        w_capture_mem = 1'b0;
        case (r_state)
            IDLE: begin
                // Reads take priority; a write raised alongside stays pending.
                if (l2_pmem_read) begin
                    if (w_match) begin
                        w_capture_hit = 1'b1;
                        w_state_next  = RESP;
                    end else begin
                        w_state_next  = MEM_READ;
                    end
                end else if (l2_pmem_write) begin
                    if (w_match) begin
                        w_coalesce   = 1'b1;
                        w_state_next = RESP;
                    end else if (!ewb_full) begin
                        w_enq        = 1'b1;
                        w_state_next = RESP;
                    end else begin
                        w_state_next = DRAIN;
                    end
                end else if (!ewb_empty) begin
                    w_state_next = DRAIN;
                end
            end
            MEM_READ: begin
                pmem_read    = 1'b1;
                pmem_address = l2_pmem_address;
                if (pmem_resp) begin
                    w_capture_mem = 1'b1;
                    w_state_next  = RESP;
                end
            end
            DRAIN: begin
                pmem_write = 1'b1;
                if (pmem_resp) begin
                    w_pop        = 1'b1;
                    w_state_next = IDLE;
                end
            end
            RESP: begin
                l2_pmem_resp = 1'b1;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_eviction_write_queue.sv
// Directed bench for eviction_write_queue with a FIFO-ordered line model and
// a latency-programmable physical memory responder.
module tb_eviction_write_queue;

    localparam int DEPTH = 4;
    localparam int AW    = 16;
    localparam int DW    = 256;

    logic          clk = 1'b0;
    logic          rst;
    logic          l2_pmem_read;
    logic          l2_pmem_write;
    logic [AW-1:0] l2_pmem_address;
    logic [DW-1:0] l2_pmem_wdata;
    logic [DW-1:0] l2_pmem_rdata;
    logic          l2_pmem_resp;
    logic          pmem_resp;
    logic [DW-1:0] pmem_rdata;
    logic          pmem_read;
    logic          pmem_write;
    logic [AW-1:0] pmem_address;
    logic [DW-1:0] pmem_wdata;
    logic          ewb_empty;
    logic          ewb_full;

    eviction_write_queue #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk             (clk),
        .rst             (rst),
        .l2_pmem_read    (l2_pmem_read),
        .l2_pmem_write   (l2_pmem_write),
        .l2_pmem_address (l2_pmem_address),
        .l2_pmem_wdata   (l2_pmem_wdata),
        .l2_pmem_rdata   (l2_pmem_rdata),
        .l2_pmem_resp    (l2_pmem_resp),
        .pmem_resp       (pmem_resp),
        .pmem_rdata      (pmem_rdata),
        .pmem_read       (pmem_read),
        .pmem_write      (pmem_write),
        .pmem_address    (pmem_address),
        .pmem_wdata      (pmem_wdata),
        .ewb_empty       (ewb_empty),
        .ewb_full        (ewb_full)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } line_t;

    int            checks = 0;
    int            errors = 0;
    line_t         sb_q[$];
    logic [DW-1:0] rd_exp_q[$];
    bit            pmem_en  = 1'b0;
    int            pmem_lat = 1;
    logic [DW-1:0] mem_value = '0;
    logic [AW-1:0] exp_rd_addr = '0;
    int            drains = 0;
    int            saw_rd = 0;
    int            saw_wr = 0;
    int            saw_resp = 0;

    localparam logic [DW-1:0] D1 = {8{32'h1111_0001}};
    localparam logic [DW-1:0] DA = {8{32'hAAAA_0002}};
    localparam logic [DW-1:0] DB = {8{32'hBBBB_0003}};
    localparam logic [DW-1:0] DC = {8{32'hCCCC_0004}};
    localparam logic [DW-1:0] DE = {8{32'hEEEE_0005}};
    localparam logic [DW-1:0] DG = {8{32'h6666_0006}};
    localparam logic [DW-1:0] DH = {8{32'h4444_0007}};
    localparam logic [DW-1:0] DJ = {8{32'h7777_0008}};

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int sb_find(input logic [AW-1:0] a);
        for (int i = 0; i < sb_q.size(); i++) begin
            if (sb_q[i].addr[AW-1:5] == a[AW-1:5]) return i;
        end
        return -1;
    endfunction

    // Physical memory: answers after pmem_lat active cycles while enabled and
    // scores every drained line against the front of the line model.
    initial begin
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        forever begin
            int wcnt;
            @(posedge clk);
            #1;
            pmem_resp = 1'b0;
            if (pmem_read)    saw_rd++;
            if (pmem_write)   saw_wr++;
            if (l2_pmem_resp) saw_resp++;
            check("pmem_rd_wr_exclusive", pmem_read & pmem_write, 0);
            if ((pmem_read || pmem_write) && pmem_en) begin
                wcnt++;
                if (wcnt >= pmem_lat) begin
                    wcnt = 0;
                    pmem_resp = 1'b1;
                    if (pmem_write) begin
                        drains++;
                        check("drain_pending", sb_q.size() > 0, 1);
                        if (sb_q.size() > 0) begin
                            line_t ln;
                            ln = sb_q.pop_front();
                            check("drain_addr", pmem_address, {ln.addr[AW-1:5], 5'b0});
                            check("drain_data", pmem_wdata, ln.data);
                            $display("drain  addr=%h", pmem_address);
                        end
                    end else begin
                        check("read_addr", pmem_address, exp_rd_addr);
                        pmem_rdata = mem_value;
                        $display("pmemrd addr=%h", pmem_address);
                    end
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    // Holds the request until resp (bounded), then releases it just after the
    // edge that leaves RESP so a following call lands back-to-back.
    task automatic l2_req(input logic rd, input logic wr, input logic [AW-1:0] addr,
                          input logic [DW-1:0] data, output int cyc);
        l2_pmem_read    = rd;
        l2_pmem_write   = wr;
        l2_pmem_address = addr;
        l2_pmem_wdata   = data;
        cyc = 0;
        while (cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (l2_pmem_resp) break;
        end
        check("l2_resp_seen", l2_pmem_resp, 1);
        if (rd) begin
            logic [DW-1:0] e;
            e = rd_exp_q.pop_front();
            check("l2_rdata", l2_pmem_rdata, e);
        end else if (wr) begin
            int k;
            k = sb_find(addr);
            if (k >= 0) begin
                sb_q[k].data = data;
            end else begin
                line_t ln;
                ln.addr = addr;
                ln.data = data;
                sb_q.push_back(ln);
            end
        end
        $display("l2 rd=%0d wr=%0d addr=%h cycles=%0d", rd, wr, addr, cyc);
        @(posedge clk);
        #1;
        l2_pmem_read  = 1'b0;
        l2_pmem_write = 1'b0;
    endtask

    task automatic l2_write(input logic [AW-1:0] addr, input logic [DW-1:0] data, output int cyc);
        l2_req(1'b0, 1'b1, addr, data, cyc);
    endtask

    task automatic l2_read(input logic [AW-1:0] addr, input logic also_wr, output int cyc);
        int k;
        k = sb_find(addr);
        rd_exp_q.push_back((k >= 0) ? sb_q[k].data : mem_value);
        exp_rd_addr = addr;
        l2_req(1'b1, also_wr, addr, DE, cyc);
    endtask

    task automatic wait_empty();
        int n;
        n = 0;
        while (!ewb_empty && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("wait_empty", ewb_empty, 1);
    endtask

    initial begin
        int cyc;
        int d0;
        int s0;
        int r0;
        rst             = 1'b1;
        l2_pmem_read    = 1'b0;
        l2_pmem_write   = 1'b0;
        l2_pmem_address = '0;
        l2_pmem_wdata   = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_pmem_read", pmem_read, 0);
        check("rst_pmem_write", pmem_write, 0);
        check("rst_l2_resp", l2_pmem_resp, 0);
        check("rst_empty", ewb_empty, 1);
        check("rst_full", ewb_full, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Write then read the same line: forwarded hit, two-cycle latency each.
        s0 = saw_rd;
        l2_write(16'h1000, D1, cyc);
        check("wr_latency", cyc, 2);
        l2_read(16'h1000, 1'b0, cyc);
        check("hit_latency", cyc, 2);
        check("hit_no_pmem_read", saw_rd - s0, 0);
        pmem_en = 1'b1;
        wait_empty();
        pmem_en = 1'b0;

        // Fill the buffer, then a fifth write must wait for the head drain.
        l2_write(16'h1000, D1, cyc);
        l2_write(16'h1020, DA, cyc);
        l2_write(16'h1040, DB, cyc);
        l2_write(16'h1060, DC, cyc);
        check("wr4_latency", cyc, 2);
        check("full_after_4", ewb_full, 1);
        s0 = saw_resp;
        l2_pmem_write   = 1'b1;
        l2_pmem_address = 16'h1080;
        l2_pmem_wdata   = DE;
        repeat (4) @(negedge clk);
        check("full_drain_write", pmem_write, 1);
        check("full_drain_addr", pmem_address, 16'h1000);
        check("full_no_accept", saw_resp - s0, 0);
        pmem_lat = 1;
        pmem_en  = 1'b1;
        l2_write(16'h1080, DE, cyc);
        wait_empty();
        check("full_empty_model", sb_q.size(), 0);

        // Coalescing: two writes to one line leave one entry, drained once.
        pmem_en = 1'b0;
        s0 = saw_rd;
        l2_write(16'h2000, DA, cyc);
        l2_write(16'h2000, DB, cyc);
        l2_read(16'h2000, 1'b0, cyc);
        check("coal_fwd_no_pmem", saw_rd - s0, 0);
        check("coal_not_full", ewb_full, 0);
        d0 = drains;
        pmem_en = 1'b1;
        wait_empty();
        check("coal_one_drain", drains - d0, 1);

        // Read miss with a line buffered: memory read first, no drain interleaved.
        pmem_lat  = 5;
        mem_value = DC;
        l2_write(16'h4000, DE, cyc);
        s0 = saw_wr;
        r0 = saw_rd;
        l2_read(16'h3000, 1'b0, cyc);
        check("miss_latency", cyc, 7);
        check("miss_no_drain", saw_wr - s0, 0);
        check("miss_read_cycles", saw_rd - r0, 5);
        wait_empty();

        // Read and write together: read serviced, write not absorbed.
        pmem_lat  = 1;
        mem_value = DG;
        l2_read(16'h5000, 1'b1, cyc);
        check("rdwr_write_pending", ewb_empty, 1);

        // Idle drain of three lines in FIFO order.
        pmem_en = 1'b0;
        l2_write(16'h6000, DA, cyc);
        l2_write(16'h6020, DB, cyc);
        l2_write(16'h6040, DC, cyc);
        repeat (2) @(negedge clk);
        check("idle_drain_write", pmem_write, 1);
        check("idle_drain_head", pmem_address, 16'h6000);
        d0 = drains;
        pmem_lat = 2;
        pmem_en  = 1'b1;
        wait_empty();
        check("idle_three_drains", drains - d0, 3);

        // Reset mid-drain discards the buffered line.
        pmem_en = 1'b0;
        l2_write(16'h7000, DH, cyc);
        repeat (3) @(negedge clk);
        check("pre_rst_drain", pmem_write, 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb_q.delete();
        check("rst_mid_pmem_write", pmem_write, 0);
        check("rst_mid_empty", ewb_empty, 1);
        check("rst_mid_full", ewb_full, 0);
        pmem_lat  = 1;
        pmem_en   = 1'b1;
        mem_value = DJ;
        s0 = saw_rd;
        l2_read(16'h7000, 1'b0, cyc);
        check("rst_read_misses", (saw_rd - s0) > 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
